// File: rtl/decode_stage.sv
// RV32I decode stage: DEPTH-entry FIFO feeding one registered decode output.
// The input bypasses straight into the output register when the FIFO is empty.
module decode_stage #(
  parameter int unsigned XLEN  = 32,
  parameter int unsigned DEPTH = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     in_instr,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_pc,
  output logic [6:0]      out_opcode,
  output logic [4:0]      out_rd,
  output logic [2:0]      out_funct3,
  output logic [4:0]      out_rs1,
  output logic [4:0]      out_rs2,
  output logic [6:0]      out_funct7,
  output logic [11:0]     out_csr,
  output logic [XLEN-1:0] out_imm,
  output logic [10:0]     out_class,
  output logic            out_illegal,
  output logic [$clog2(DEPTH+2)-1:0] occupancy
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned OCC_W = $clog2(DEPTH + 2);

  logic [31:0]     instr_mem [DEPTH];
  logic [XLEN-1:0] pc_mem    [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count, count_n;
  logic [31:0]     out_instr;

  logic push, load_out, fifo_empty, pop_fifo, bypass, write_fifo, valid_n;
  logic [31:0]     src_instr;
  logic [XLEN-1:0] src_pc;
  logic [XLEN-1:0] dec_imm;
  logic [10:0]     dec_class;
  logic            dec_illegal;

  assign in_ready   = (count < CNT_W'(DEPTH)) && !rst;
  assign push       = in_valid && in_ready;
  assign fifo_empty = (count == '0);
  assign load_out   = !out_valid || out_ready;
  assign pop_fifo   = load_out && !fifo_empty;
  assign bypass     = load_out && fifo_empty && push;
  assign write_fifo = push && !bypass;
  assign valid_n    = load_out ? (!fifo_empty || push) : 1'b1;
  assign count_n    = count + CNT_W'(write_fifo) - CNT_W'(pop_fifo);

  assign src_instr  = fifo_empty ? in_instr : instr_mem[rd_ptr];
  assign src_pc     = fifo_empty ? in_pc    : pc_mem[rd_ptr];

  // Decode of whichever word is about to enter the output register
  always_comb begin
    dec_imm     = '0;
    dec_class   = '0;
    dec_illegal = 1'b0;
    case (src_instr[6:0])
      7'b0000011: begin dec_class = 11'b000_0000_0001; dec_imm = XLEN'($signed(src_instr[31:20])); end
      7'b0100011: begin
        dec_class = 11'b000_0000_0010;
        dec_imm   = XLEN'($signed({src_instr[31:25], src_instr[11:7]}));
      end
      7'b1100011: begin
        dec_class = 11'b000_0000_0100;
        dec_imm   = XLEN'($signed({src_instr[31], src_instr[7], src_instr[30:25],
                                   src_instr[11:8], 1'b0}));
      end
      7'b1101111: begin
        dec_class = 11'b000_0000_1000;
        dec_imm   = XLEN'($signed({src_instr[31], src_instr[19:12], src_instr[20],
                                   src_instr[30:21], 1'b0}));
      end
      7'b1100111: begin dec_class = 11'b000_0001_0000; dec_imm = XLEN'($signed(src_instr[31:20])); end
      7'b0110111: begin dec_class = 11'b000_0010_0000; dec_imm = XLEN'($signed({src_instr[31:12], 12'h000})); end
      7'b0010111: begin dec_class = 11'b000_0100_0000; dec_imm = XLEN'($signed({src_instr[31:12], 12'h000})); end
      7'b1110011: begin dec_class = 11'b000_1000_0000; dec_imm = XLEN'($signed(src_instr[31:20])); end
      7'b0010011: begin dec_class = 11'b001_0000_0000; dec_imm = XLEN'($signed(src_instr[31:20])); end
      7'b0110011: dec_class = 11'b010_0000_0000;
      7'b0001111: dec_class = 11'b100_0000_0000;
      default:    dec_illegal = 1'b1;
    endcase
  end

  // FIFO storage carries no reset; validity is tracked by count
  always_ff @(posedge clk) begin
    if (write_fifo && !flush && !rst) begin
      instr_mem[wr_ptr] <= in_instr;
      pc_mem[wr_ptr]    <= in_pc;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      out_valid <= 1'b0;
      occupancy <= '0;
      if (rst) begin
        out_pc      <= '0;
        out_instr   <= '0;
        out_imm     <= '0;
        out_class   <= '0;
        out_illegal <= 1'b0;
      end
    end else begin
      if (write_fifo) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_fifo)   rd_ptr <= rd_ptr + PTR_W'(1);
      count     <= count_n;
      out_valid <= valid_n;
      occupancy <= OCC_W'(count_n) + OCC_W'(valid_n);
      if (pop_fifo || bypass) begin
        out_pc      <= src_pc;
        out_instr   <= src_instr;
        out_imm     <= dec_imm;
        out_class   <= dec_class;
        out_illegal <= dec_illegal;
      end
    end
  end

  assign out_opcode = out_instr[6:0];
  assign out_rd     = out_instr[11:7];
  assign out_funct3 = out_instr[14:12];
  assign out_rs1    = out_instr[19:15];
  assign out_rs2    = out_instr[24:20];
  assign out_funct7 = out_instr[31:25];
  assign out_csr    = out_instr[31:20];

endmodule

// File: tb/tb_decode_stage.sv
// Scoreboard bench for decode_stage: expected decodes queued on input
// handshake, compared when the output is consumed.
module tb_decode_stage;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        flush = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] in_instr = '0;
  logic [31:0] in_pc = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [2:0]  out_funct3;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [6:0]  out_funct7;
  logic [11:0] out_csr;
  logic [31:0] out_imm;
  logic [10:0] out_class;
  logic        out_illegal;
  logic [2:0]  occupancy;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] imm;
    logic [10:0] cls;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  decode_stage #(.XLEN(32), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_funct3(out_funct3),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_funct7(out_funct7), .out_csr(out_csr),
    .out_imm(out_imm), .out_class(out_class), .out_illegal(out_illegal),
    .occupancy(occupancy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // Reference decoder written straight from the RV32I field layouts
  function automatic exp_t ref_decode(input logic [31:0] ins, input logic [31:0] pc);
    exp_t e;
    e.pc = pc; e.instr = ins; e.imm = '0; e.cls = '0; e.ill = 1'b0;
    case (ins[6:0])
      7'b0000011: begin e.cls = 11'h001; e.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b0100011: begin e.cls = 11'h002; e.imm = {{20{ins[31]}}, ins[31:25], ins[11:7]}; end
      7'b1100011: begin e.cls = 11'h004; e.imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; end
      7'b1101111: begin e.cls = 11'h008; e.imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; end
      7'b1100111: begin e.cls = 11'h010; e.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b0110111: begin e.cls = 11'h020; e.imm = {ins[31:12], 12'h000}; end
      7'b0010111: begin e.cls = 11'h040; e.imm = {ins[31:12], 12'h000}; end
      7'b1110011: begin e.cls = 11'h080; e.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b0010011: begin e.cls = 11'h100; e.imm = {{20{ins[31]}}, ins[31:20]}; end
      7'b0110011: e.cls = 11'h200;
      7'b0001111: e.cls = 11'h400;
      default:    e.ill = 1'b1;
    endcase
    return e;
  endfunction

  // Scoreboard monitor: pop on consume, then flush/reset kill, then push on accept
  always @(negedge clk) begin
    exp_t e;
    if (out_valid === 1'b1 && out_ready === 1'b1) begin
      if (sb.size() == 0) chk("sb_extra_output", 32'd1, 32'd0);
      else begin
        e = sb.pop_front();
        chk("sb_pc", out_pc, e.pc);
        chk("sb_fields", {out_funct7, out_rs2, out_rs1, out_funct3, out_rd, out_opcode}, e.instr);
        chk("sb_imm", out_imm, e.imm);
        chk("sb_class", 32'(out_class), 32'(e.cls));
        chk("sb_illegal", 32'(out_illegal), 32'(e.ill));
      end
    end
    if (rst || flush) sb.delete();
    else if (in_valid && in_ready) sb.push_back(ref_decode(in_instr, in_pc));
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic push_word(input logic [31:0] pc, input logic [31:0] ins);
    bit done;
    done = 1'b0;
    in_valid = 1'b1; in_pc = pc; in_instr = ins;
    for (int i = 0; i < 50 && !done; i++) begin
      if (in_ready) done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!done) chk("push_timeout", 32'd0, 32'd1);
  endtask

  task automatic drain;
    out_ready = 1'b1;
    for (int i = 0; i < 40 && sb.size() != 0; i++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  logic [31:0] t2_word [4] = '{32'h0040A103, 32'h0020A423, 32'hFE000EE3, 32'h123452B7};
  logic [31:0] t2_imm  [4] = '{32'h00000004, 32'h00000008, 32'hFFFFFFFC, 32'h12345000};
  logic [10:0] t2_cls  [4] = '{11'h001, 11'h002, 11'h004, 11'h020};
  logic [6:0]  ops     [12] = '{7'b0000011, 7'b0100011, 7'b1100011, 7'b1101111,
                                7'b1100111, 7'b0110111, 7'b0010111, 7'b1110011,
                                7'b0110011, 7'b0010011, 7'b0001111, 7'b0101010};

  initial begin
    logic [31:0] r;
    // Reset state
    tick(); tick();
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_occupancy", 32'(occupancy), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd0);
    chk("rst_out_pc", out_pc, 32'd0);
    rst = 1'b0;
    tick();
    chk("post_rst_in_ready", 32'(in_ready), 32'd1);

    // Test 1: single push, 1-cycle latency
    out_ready = 1'b1;
    in_valid = 1'b1; in_pc = 32'h100; in_instr = 32'hFFF00093;
    tick();
    in_valid = 1'b0;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_class", 32'(out_class), 32'h100);
    chk("t1_rd", 32'(out_rd), 32'd1);
    chk("t1_rs1", 32'(out_rs1), 32'd0);
    chk("t1_imm", out_imm, 32'hFFFFFFFF);
    chk("t1_pc", out_pc, 32'h100);
    chk("t1_csr", 32'(out_csr), 32'hFFF);
    tick();

    // Test 2: back-to-back through the bypass
    for (int k = 0; k < 4; k++) begin
      in_valid = 1'b1; in_pc = 32'h200 + 32'(4 * k); in_instr = t2_word[k];
      tick();
      chk("t2_imm", out_imm, t2_imm[k]);
      chk("t2_class", 32'(out_class), 32'(t2_cls[k]));
    end
    in_valid = 1'b0;
    chk("t2_rd_lui", 32'(out_rd), 32'd5);
    tick();

    // Test 3: fill with output stalled
    out_ready = 1'b0;
    for (int k = 0; k < 6; k++) begin
      in_valid = 1'b1; in_pc = 32'h300 + 32'(4 * k);
      in_instr = {12'(k + 1), 5'd0, 3'b000, 5'd3, 7'b0010011};
      chk("t3_in_ready", 32'(in_ready), (k < 5) ? 32'd1 : 32'd0);
      tick();
    end
    in_valid = 1'b0;
    chk("t3_occupancy", 32'(occupancy), 32'd5);
    chk("t3_hold_pc", out_pc, 32'h300);
    tick(); tick();
    chk("t3_stable_pc", out_pc, 32'h300);
    chk("t3_stable_imm", out_imm, 32'd1);
    chk("t3_stable_valid", 32'(out_valid), 32'd1);
    drain();
    tick();

    // Test 4: illegal all-zero word
    in_valid = 1'b1; in_pc = 32'h400; in_instr = 32'h00000000;
    tick();
    in_valid = 1'b0;
    chk("t4_illegal", 32'(out_illegal), 32'd1);
    chk("t4_class", 32'(out_class), 32'd0);
    chk("t4_imm", out_imm, 32'd0);
    chk("t4_valid", 32'(out_valid), 32'd1);
    tick();

    // Test 5: flush with three FIFO entries and a colliding input
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) push_word(32'h500 + 32'(4 * k), 32'h00000013 | (32'(k) << 20));
    chk("t5_pre_occupancy", 32'(occupancy), 32'd4);
    flush = 1'b1; in_valid = 1'b1; in_pc = 32'hDEAD0; in_instr = 32'h00700393;
    tick();
    flush = 1'b0; in_valid = 1'b0;
    chk("t5_occupancy", 32'(occupancy), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    out_ready = 1'b1;
    push_word(32'h600, 32'h00500313);
    chk("t5_after_valid", 32'(out_valid), 32'd1);
    chk("t5_after_pc", out_pc, 32'h600);
    drain();

    // Test 6: random traffic with pointer wrap, fill, then reset mid-stream
    for (int k = 0; k < 12; k++) begin
      r = $urandom;
      out_ready = r[0] | r[1];
      push_word(32'h700 + 32'(4 * k), {r[31:7], ops[$urandom_range(0, 11)]});
    end
    out_ready = 1'b0;
    for (int k = 0; k < 8; k++) begin
      if (!in_ready) break;
      r = $urandom;
      push_word(32'h800 + 32'(4 * k), {r[31:7], ops[$urandom_range(0, 11)]});
    end
    chk("t6_full_ready", 32'(in_ready), 32'd0);
    rst = 1'b1; in_valid = 1'b1; in_instr = 32'h00100093; in_pc = 32'h900;
    tick();
    in_valid = 1'b0;
    chk("t6_valid", 32'(out_valid), 32'd0);
    chk("t6_pc", out_pc, 32'd0);
    chk("t6_imm", out_imm, 32'd0);
    chk("t6_class", 32'(out_class), 32'd0);
    chk("t6_opcode", 32'(out_opcode), 32'd0);
    chk("t6_occupancy", 32'(occupancy), 32'd0);
    chk("t6_in_ready_rst", 32'(in_ready), 32'd0);
    rst = 1'b0;
    #1;
    chk("t6_in_ready", 32'(in_ready), 32'd1);
    out_ready = 1'b1;
    for (int k = 0; k < 4; k++) push_word(32'hA00 + 32'(4 * k), t2_word[k]);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
